// File: rtl/capture_scheduler_pkg.sv
// Shared types and constants for the acquisition frame scheduler.
package capture_scheduler_pkg;

    localparam int unsigned CNT_W   = 10;
    localparam int unsigned TIMER_W = 24;
    localparam int unsigned BYTE_W  = 8;

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE     = 4'd0;
    localparam state_t ST_CAPTURE  = 4'd1;
    localparam state_t ST_SEND_H0  = 4'd2;
    localparam state_t ST_SEND_H1  = 4'd3;
    localparam state_t ST_SEND_CH  = 4'd4;
    localparam state_t ST_SEND_CL  = 4'd5;
    localparam state_t ST_RD       = 4'd6;
    localparam state_t ST_SEND_D   = 4'd7;
    localparam state_t ST_SEND_SUM = 4'd8;
    localparam state_t ST_DONE     = 4'd9;

    localparam logic [BYTE_W-1:0] CMD_LEN_BASE = 8'h01;
    localparam logic [BYTE_W-1:0] CMD_LEN_LAST = 8'h04;
    localparam logic [BYTE_W-1:0] CMD_SINGLE   = 8'h10;
    localparam logic [BYTE_W-1:0] CMD_CONT     = 8'h11;
    localparam logic [BYTE_W-1:0] CMD_STOP     = 8'h20;

    localparam logic [BYTE_W-1:0] HDR0_DEF = 8'hA5;
    localparam logic [BYTE_W-1:0] HDR1_DEF = 8'h5A;

    // len_code 0..3 maps to 64/128/256/512 samples
    function automatic logic [CNT_W-1:0] frame_len_of(input logic [1:0] code);
        return CNT_W'(64) << code;
    endfunction

endpackage

// File: rtl/capture_scheduler_cmd_decode.sv
// Host command decoder: frame length, continuous flag and start request.
module cap_cmd_decode
    import capture_scheduler_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [BYTE_W-1:0] cmd_data,
    input  logic              cmd_valid,
    input  logic              key,
    output logic [1:0]        len_code,
    output logic              continuous,
    output logic              start_c
);

    // Start is passed through combinationally so adc_en can rise one cycle after the strobe
    always_comb begin
        start_c = key || (cmd_valid && (cmd_data == CMD_SINGLE || cmd_data == CMD_CONT));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_code   <= 2'd0;
            continuous <= 1'b0;
        end else if (cmd_valid) begin
            if (cmd_data >= CMD_LEN_BASE && cmd_data <= CMD_LEN_LAST) begin
                len_code <= 2'(cmd_data - CMD_LEN_BASE);
            end
            if (cmd_data == CMD_CONT) begin
                continuous <= 1'b1;
            end
            if (cmd_data == CMD_STOP) begin
                continuous <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/capture_scheduler.sv
// Sequences one ADC capture into the FIFO, then drains it to the UART as a framed packet.
module capture_scheduler
    import capture_scheduler_pkg::*;
#(
    parameter logic [BYTE_W-1:0]  HDR0    = HDR0_DEF,
    parameter logic [BYTE_W-1:0]  HDR1    = HDR1_DEF,
    parameter logic [TIMER_W-1:0] TIMEOUT = 24'd2_400_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [BYTE_W-1:0] cmd_data,
    input  logic              cmd_valid,
    input  logic              key,
    output logic              adc_en,
    input  logic              data_en,
    input  logic              fifo_empty,
    output logic              fifo_rd,
    input  logic [BYTE_W-1:0] fifo_q,
    output logic [BYTE_W-1:0] tx_data,
    output logic              tx_vld,
    input  logic              tx_busy,
    output logic              busy,
    output logic              frame_done
);

    logic [1:0] len_code;
    logic       continuous;
    logic       start_c;

    cap_cmd_decode u_cmd_decode (
        .clk        (clk),
        .reset      (reset),
        .cmd_data   (cmd_data),
        .cmd_valid  (cmd_valid),
        .key        (key),
        .len_code   (len_code),
        .continuous (continuous),
        .start_c    (start_c)
    );

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   sample_cnt, cnt_nxt;
    logic [CNT_W-1:0]   remaining, rem_nxt;
    logic [CNT_W-1:0]   frame_len, len_nxt;
    logic [TIMER_W-1:0] timer, timer_nxt;
    logic               err, err_nxt;
    logic [BYTE_W-1:0]  sum, sum_nxt;
    logic [BYTE_W-1:0]  tx_data_nxt, tx_byte;
    logic               tx_vld_nxt, fifo_rd_nxt, send_ok, issue;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            sample_cnt <= '0;
            remaining  <= '0;
            frame_len  <= '0;
            timer      <= '0;
            err        <= 1'b0;
            sum        <= '0;
            adc_en     <= 1'b0;
            fifo_rd    <= 1'b0;
            tx_vld     <= 1'b0;
            tx_data    <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            sample_cnt <= cnt_nxt;
            remaining  <= rem_nxt;
            frame_len  <= len_nxt;
            timer      <= timer_nxt;
            err        <= err_nxt;
            sum        <= sum_nxt;
            adc_en     <= (state_nxt == ST_CAPTURE);
            fifo_rd    <= fifo_rd_nxt;
            tx_vld     <= tx_vld_nxt;
            tx_data    <= tx_data_nxt;
            busy       <= (state_nxt != ST_IDLE);
            frame_done <= (state_nxt == ST_DONE);
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = sample_cnt;
        rem_nxt     = remaining;
        len_nxt     = frame_len;
        timer_nxt   = timer;
        err_nxt     = err;
        sum_nxt     = sum;
        fifo_rd_nxt = 1'b0;
        tx_vld_nxt  = 1'b0;
        tx_data_nxt = tx_data;
        tx_byte     = '0;
        issue       = 1'b0;
        send_ok     = !tx_busy && !tx_vld;

        case (state)
            ST_IDLE: begin
                if (start_c) begin
                    state_nxt = ST_CAPTURE;
                    cnt_nxt   = '0;
                    timer_nxt = '0;
                    err_nxt   = 1'b0;
                    sum_nxt   = '0;
                    len_nxt   = frame_len_of(len_code);
                end
            end
            ST_CAPTURE: begin
                if (data_en) begin
                    cnt_nxt   = sample_cnt + CNT_W'(1);
                    timer_nxt = '0;
                    if (cnt_nxt == frame_len) begin
                        state_nxt = ST_SEND_H0;
                        rem_nxt   = cnt_nxt;
                    end
                end else begin
                    timer_nxt = timer + TIMER_W'(1);
                    if (timer_nxt == TIMEOUT) begin
                        err_nxt   = 1'b1;
                        state_nxt = ST_SEND_H0;
                        rem_nxt   = sample_cnt;
                    end
                end
            end
            ST_SEND_H0:  if (tx_vld) state_nxt = ST_SEND_H1;
            ST_SEND_H1:  if (tx_vld) state_nxt = ST_SEND_CH;
            ST_SEND_CH:  if (tx_vld) state_nxt = ST_SEND_CL;
            ST_SEND_CL:  if (tx_vld) state_nxt = ST_RD;
            ST_SEND_D:   if (tx_vld) state_nxt = ST_RD;
            ST_SEND_SUM: if (tx_vld) state_nxt = ST_DONE;
            ST_RD: begin
                if (remaining == '0) begin
                    state_nxt = ST_SEND_SUM;
                end else if (!fifo_empty) begin
                    fifo_rd_nxt = 1'b1;
                    state_nxt   = ST_SEND_D;
                end
            end
            ST_DONE: begin
                if (continuous) begin
                    state_nxt = ST_CAPTURE;
                    cnt_nxt   = '0;
                    timer_nxt = '0;
                    err_nxt   = 1'b0;
                    sum_nxt   = '0;
                    len_nxt   = frame_len_of(len_code);
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Launch the byte of the state we will be in, so tx_vld is high while that state holds
        case (state_nxt)
            ST_SEND_H0: begin
                issue   = send_ok;
                tx_byte = HDR0;
            end
            ST_SEND_H1: begin
                issue   = send_ok;
                tx_byte = HDR1;
            end
            ST_SEND_CH: begin
                issue   = send_ok;
                tx_byte = {err, 5'b0, sample_cnt[9:8]};
            end
            ST_SEND_CL: begin
                issue   = send_ok;
                tx_byte = sample_cnt[7:0];
            end
            ST_SEND_D: begin
                // fifo_q is valid only once the read strobe has retired
                issue   = send_ok && (state == ST_SEND_D) && !fifo_rd;
                tx_byte = fifo_q;
            end
            ST_SEND_SUM: begin
                issue   = send_ok;
                tx_byte = sum;
            end
            default: issue = 1'b0;
        endcase

        if (issue) begin
            tx_vld_nxt  = 1'b1;
            tx_data_nxt = tx_byte;
            if (state_nxt == ST_SEND_D) begin
                sum_nxt = sum + fifo_q;
                rem_nxt = remaining - CNT_W'(1);
            end
        end
    end

endmodule
